dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Operand-side driver for the DSP48A1 slice: accepts a stream of 18-bit A/B operand pairs over a valid/ready handshake and issues them to the slice's A/B/OPMODE pins so that N_TERMS products are accumulated in the slice's P register. It tracks the slice pipeline, and when the last term has drained it captures the 48-bit P value into a result register with its own valid/ready handshake. It sits between a sample/coefficient source and one DSP slice; the slice's A, B, OPMODE, CE* and RST* pins connect only to this block.

## Interface
- N_TERMS, 8: products per dot product; legal range 1..1023.
- CNT_W, 10: term counter width.
- OPMODE_DLY, 1: cycles DSP_OPMODE lags DSP_A/DSP_B for the same term.
- LATENCY, 4: edges from the last-term input handshake to the R_DATA capture edge.
- CLK  in  1  rising-edge clock.
- RSTN  in  1  reset: synchronous, active-low.
- S_VALID  in  1  operand pair valid.
- S_READY  out  1  operand pair accepted on an edge where S_VALID=1.
- S_A, S_B  in  18  unsigned operands.
- SUB  in  1  mode, sampled at the first-term handshake. 0 = sum of products; 1 = negated sum.
- R_VALID  out  1  result valid.
- R_READY  in  1  result consumed.
- R_DATA  out  48  result.
- DSP_A, DSP_B  out  18  to the slice's A and B pins (registered).
- DSP_OPMODE  out  8  to the slice's OPMODE pin (registered).
- DSP_CE  out  1  to all slice CE* pins.
- DSP_RST  out  1  active-high, to all slice RST* pins; equals ~RSTN.
- DSP_P  in  48  from the slice's P pin.
- BUSY  out  1  state ≠ IDLE.

## Operation
- Target slice configuration: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".
- Every cycle is one issue slot. Each slot's opcode enters an OPMODE_DLY-deep delay line that feeds DSP_OPMODE.
- Slot opcodes:
  - first term: 8'h01 (X=M, Z=0, add). With SUB=1: 8'h81.
  - later terms: 8'h09 (Z=P). With SUB=1: 8'h89.
  - bubble after the first term: 8'h08 (X=0, P holds).
  - bubble before the first term: 8'h00.
- Pre-adder (bit 4) and carry (bit 5) are always 0.
- FSM:
  - IDLE: S_READY=1. On handshake: latch SUB, issue the first term, cnt←1. Go to DRAIN if N_TERMS=1, else ACCUM.
  - ACCUM: S_READY=1. On handshake: issue a term, cnt←cnt+1. If this is term N_TERMS-1, go to DRAIN with drain counter←LATENCY-1. Without a handshake, issue a bubble.
  - DRAIN: S_READY=0. Issue bubbles and decrement the counter. At 0, R_DATA←DSP_P, R_VALID←1, go to HOLD.
  - HOLD: S_READY=0, R_VALID=1, R_DATA stable. When R_READY=1: R_VALID←0, go to IDLE.
- Arithmetic:
  - Products are unsigned 36-bit, zero-extended to 48 bits.
  - Accumulation wraps modulo 2^48. SUB=1 yields (0 − Σ products) mod 2^48.
- DSP_A/DSP_B load S_A/S_B only on handshake and otherwise hold. Their value is irrelevant during bubbles because X=0.
- DSP_CE=1 whenever RSTN=1.

## Timing
- Reset (RSTN low at an edge) sets:
  - state=IDLE, cnt=0;
  - S_READY=0 while RSTN=0, 1 in the first cycle after release;
  - R_VALID=0, R_DATA=0;
  - DSP_A=DSP_B=0, DSP_OPMODE=0, delay line cleared;
  - DSP_CE=0, DSP_RST=1 combinationally while RSTN=0.
- Reset mid-vector or in HOLD abandons the vector and the result. No partial result is ever output.
- Term handshake at edge e: DSP_A/DSP_B valid from e. The slice's A1/B1 registers capture at e+1, M at e+2, P at e+3. DSP_OPMODE shows the term's opcode from e+OPMODE_DLY.
- R_DATA is captured at the last-term handshake edge +LATENCY (default e+4). R_VALID rises the same edge.
- The first-term handshake can occur the cycle after the HOLD→IDLE edge. Back-to-back vectors share no state because the first term uses Z=0.
- Simultaneous R_VALID·R_READY at a HOLD edge: transfer completes and the FSM is in IDLE next cycle. S_READY is not asserted in the same cycle as R_VALID.
- Throughput: one term per cycle. Per-vector overhead is LATENCY cycles plus 1 HOLD cycle minimum.

## Test plan
- N_TERMS=8, SUB=0, A=k+1, B=2 (k=0..7), continuous S_VALID → R_DATA=72 (48'h48), with R_VALID rising exactly 4 edges after the 8th handshake.
- Same vector with S_VALID low for 3 cycles between terms 3 and 4 → R_DATA=72, and DSP_OPMODE=8'h08 for exactly 3 slots.
- SUB=1, A=B=3, 8 terms → R_DATA=48'hFFFF_FFFF_FFB8.
- A=B=18'h3FFFF, 8 terms → R_DATA=48'h007F_FFC0_0008.
- Backpressure:
  - hold R_READY=0 for 10 cycles → R_VALID=1, R_DATA stable, S_READY=0 throughout;
  - then release and send A=B=1 ×8 → second result=8, with no residue from the first vector.
- Assert RSTN=0 for one edge after 5 terms → R_VALID=0 and S_READY=1 in the next cycle; the following full vector (first test's stimulus) yields 72.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: operand-side driver for a DSP48A1 slice. Issues A/B
// operand pairs and OPMODE codes so that N_TERMS products accumulate in the
// slice P register, then captures P into a result register with a
// valid/ready handshake once the last term has drained through the slice.
module dsp_mac_sequencer #(
    parameter int N_TERMS    = 8,
    parameter int CNT_W      = 10,
    parameter int OPMODE_DLY = 1,
    parameter int LATENCY    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [17:0] s_a_i,
    input  logic [17:0] s_b_i,
    input  logic        sub_i,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [47:0] r_data_o,
    output logic [17:0] dsp_a_o,
    output logic [17:0] dsp_b_o,
    output logic [7:0]  dsp_opmode_o,
    output logic        dsp_ce_o,
    output logic        dsp_rst_o,
    input  logic [47:0] dsp_p_i,
    output logic        busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // OPMODE codes: X=M/Z=0 (first term), X=M/Z=P (later terms),
    // X=0/Z=P (hold P), X=0/Z=0 (idle). Bit 7 selects subtract.
    localparam logic [7:0] OP_FIRST     = 8'h01;
    localparam logic [7:0] OP_FIRST_SUB = 8'h81;
    localparam logic [7:0] OP_NEXT      = 8'h09;
    localparam logic [7:0] OP_NEXT_SUB  = 8'h89;
    localparam logic [7:0] OP_HOLD_P    = 8'h08;
    localparam logic [7:0] OP_IDLE      = 8'h00;

    localparam int unsigned OPD = OPMODE_DLY;
    localparam int          DW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(LATENCY - 1);
    localparam logic [DW-1:0]    DCNT_ONE   = DW'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             sub_q, sub_d;
    logic             r_valid_q, r_valid_d;
    logic [47:0]      r_data_q, r_data_d;
    logic [17:0]      dsp_a_q, dsp_a_d;
    logic [17:0]      dsp_b_q, dsp_b_d;
    logic [7:0]       slot_op;
    logic [7:0]       op_dl_q [OPD+1];
    logic             fire;

    // Operands are accepted only while reset is released and the FSM is collecting terms.
    always_comb begin
        s_ready_o = rstn_i & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
        fire      = s_valid_i & s_ready_o;
    end

    // Next-state logic: FSM, term/drain counters, operand and result registers, slot opcode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        sub_d     = sub_q;
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        dsp_a_d   = dsp_a_q;
        dsp_b_d   = dsp_b_q;
        slot_op   = OP_IDLE;

        if (fire) begin
            dsp_a_d = s_a_i;
            dsp_b_d = s_b_i;
        end

        case (state_q)
            ST_IDLE: begin
                slot_op = OP_IDLE;
                if (fire) begin
                    sub_d   = sub_i;
                    slot_op = sub_i ? OP_FIRST_SUB : OP_FIRST;
                    cnt_d   = CNT_ONE;
                    if (N_TERMS == 1) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DRAIN_INIT;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                slot_op = OP_HOLD_P;
                if (fire) begin
                    slot_op = sub_q ? OP_NEXT_SUB : OP_NEXT;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DRAIN_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                slot_op = OP_HOLD_P;
                if (dcnt_q == '0) begin
                    r_data_d  = dsp_p_i;
                    r_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    dcnt_d = dcnt_q - DCNT_ONE;
                end
            end
            ST_HOLD: begin
                slot_op = OP_HOLD_P;
                if (r_ready_i) begin
                    r_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; opcode delay line shifts every slot.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            sub_q     <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            dsp_a_q   <= '0;
            dsp_b_q   <= '0;
            for (int unsigned i = 0; i <= OPD; i++) begin
                op_dl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            sub_q     <= sub_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            dsp_a_q   <= dsp_a_d;
            dsp_b_q   <= dsp_b_d;
            op_dl_q[0] <= slot_op;
            for (int unsigned i = 1; i <= OPD; i++) begin
                op_dl_q[i] <= op_dl_q[i-1];
            end
        end
    end

    // Slice-facing and status outputs.
    always_comb begin
        r_valid_o    = r_valid_q;
        r_data_o     = r_data_q;
        dsp_a_o      = dsp_a_q;
        dsp_b_o      = dsp_b_q;
        dsp_opmode_o = op_dl_q[OPD];
        dsp_ce_o     = rstn_i;
        dsp_rst_o    = ~rstn_i;
        busy_o       = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer with a cycle model of the DSP48A1 slice
// (A1/B1, M, OPMODE and P registers) closing the loop on DSP_P.
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        s_sub;
    logic        r_valid;
    logic        r_ready;
    logic [47:0] r_data;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic        dsp_rst;
    logic [47:0] dsp_p;
    logic        busy;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(
        .N_TERMS(8),
        .CNT_W(10),
        .OPMODE_DLY(1),
        .LATENCY(4)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .s_a_i(s_a),
        .s_b_i(s_b),
        .sub_i(s_sub),
        .r_valid_o(r_valid),
        .r_ready_i(r_ready),
        .r_data_o(r_data),
        .dsp_a_o(dsp_a),
        .dsp_b_o(dsp_b),
        .dsp_opmode_o(dsp_opmode),
        .dsp_ce_o(dsp_ce),
        .dsp_rst_o(dsp_rst),
        .dsp_p_i(dsp_p),
        .busy_o(busy)
    );

    // DSP48A1 slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1
    logic [17:0] a1, b1;
    logic [35:0] m;
    logic [7:0]  opm;
    logic [47:0] p, x_mux, z_mux, p_next;

    always_comb begin
        x_mux  = (opm[1:0] == 2'b01) ? {12'b0, m} : 48'b0;
        z_mux  = (opm[3:2] == 2'b10) ? p : 48'b0;
        p_next = opm[7] ? (z_mux - x_mux) : (z_mux + x_mux);
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m <= '0; opm <= '0; p <= '0;
        end else if (dsp_ce) begin
            a1  <= dsp_a;
            b1  <= dsp_b;
            m   <= 36'(a1) * 36'(b1);
            opm <= dsp_opmode;
            p   <= p_next;
        end
    end
    assign dsp_p = p;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        sub;
        logic [17:0] a [8];
        logic [17:0] b [8];
        int          gap_at;
        int          gap_len;
        int          hold;
        logic [47:0] exp_res;
        int          exp_bub;
    } vec_t;

    localparam int NV = 7;
    vec_t tbl [NV];

    // Drives one 8-term vector, checks opcodes, latency, result and handshake.
    task automatic run_vec(input vec_t v, input int idx);
        int hs_cyc;
        int t;
        int bub;
        logic [47:0] res;
        bub = 0;
        hs_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == v.gap_at) begin
                for (int g = 0; g < v.gap_len; g++) begin
                    s_valid = 1'b0;
                    @(posedge clk); @(negedge clk);
                    if (dsp_opmode == 8'h08) bub++;
                end
            end
            s_valid = 1'b1;
            s_a     = v.a[k];
            s_b     = v.b[k];
            s_sub   = v.sub;
            t = 0;
            while (!s_ready && t < 50) begin
                @(posedge clk); @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                $display("FAIL s_ready_timeout vec %0d: got 0 expected 1", idx);
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $fatal(1, "stuck");
            end
            @(posedge clk); @(negedge clk);
            hs_cyc = cyc;
            if (k >= 1 && dsp_opmode == 8'h08) bub++;
            if (k == 1 && v.gap_at != 1)
                chk($sformatf("first_op[%0d]", idx), {40'b0, dsp_opmode},
                    v.sub ? 48'h81 : 48'h01);
        end
        s_valid = 1'b0;
        chk($sformatf("bubbles[%0d]", idx), 48'(bub), 48'(v.exp_bub));

        t = 0;
        while (!r_valid && t < 20) begin
            @(posedge clk); @(negedge clk);
            t++;
            if (t == 1)
                chk($sformatf("last_op[%0d]", idx), {40'b0, dsp_opmode},
                    v.sub ? 48'h89 : 48'h09);
        end
        chk($sformatf("r_valid_seen[%0d]", idx), {47'b0, r_valid}, 48'h1);
        chk($sformatf("latency[%0d]", idx), 48'(cyc - hs_cyc), 48'd4);
        chk($sformatf("r_data[%0d]", idx), r_data, v.exp_res);
        res = r_data;

        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_valid[%0d.%0d]", idx, h), {47'b0, r_valid}, 48'h1);
            chk($sformatf("hold_data[%0d.%0d]", idx, h), r_data, res);
            chk($sformatf("hold_sready[%0d.%0d]", idx, h), {47'b0, s_ready}, 48'h0);
        end

        r_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        r_ready = 1'b0;
        chk($sformatf("ack_valid[%0d]", idx), {47'b0, r_valid}, 48'h0);
        chk($sformatf("ack_sready[%0d]", idx), {47'b0, s_ready}, 48'h1);
    endtask

    initial begin
        int quiet;

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < NV; j++) begin
                tbl[j].gap_at  = -1;
                tbl[j].gap_len = 0;
                tbl[j].hold    = 0;
                tbl[j].exp_bub = 0;
                tbl[j].sub     = 1'b0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            tbl[0].a[k] = 18'(k + 1); tbl[0].b[k] = 18'd2;
            tbl[1].a[k] = 18'(k + 1); tbl[1].b[k] = 18'd2;
            tbl[2].a[k] = 18'd3;      tbl[2].b[k] = 18'd3;
            tbl[3].a[k] = 18'h3FFFF;  tbl[3].b[k] = 18'h3FFFF;
            tbl[4].a[k] = 18'(k + 1); tbl[4].b[k] = 18'd2;
            tbl[5].a[k] = 18'd1;      tbl[5].b[k] = 18'd1;
            tbl[6].a[k] = 18'(k + 1); tbl[6].b[k] = 18'd2;
        end
        tbl[0].exp_res = 48'd72;
        tbl[1].exp_res = 48'd72;            tbl[1].gap_at = 3; tbl[1].gap_len = 3; tbl[1].exp_bub = 3;
        tbl[2].exp_res = 48'hFFFF_FFFF_FFB8; tbl[2].sub = 1'b1;
        tbl[3].exp_res = 48'h007F_FFC0_0008;
        tbl[4].exp_res = 48'd72;            tbl[4].hold = 10;
        tbl[5].exp_res = 48'd8;
        tbl[6].exp_res = 48'hFFFF_FFFF_FFB8; tbl[6].sub = 1'b1; tbl[6].gap_at = 5; tbl[6].gap_len = 2; tbl[6].exp_bub = 2;

        rstn    = 1'b0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_sub   = 1'b0;
        r_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sready", {47'b0, s_ready}, 48'h0);
        chk("rst_rvalid", {47'b0, r_valid}, 48'h0);
        chk("rst_rdata", r_data, 48'h0);
        chk("rst_dsp_a", {30'b0, dsp_a}, 48'h0);
        chk("rst_opmode", {40'b0, dsp_opmode}, 48'h0);
        chk("rst_ce", {47'b0, dsp_ce}, 48'h0);
        chk("rst_dsprst", {47'b0, dsp_rst}, 48'h1);
        chk("rst_busy", {47'b0, busy}, 48'h0);
        rstn = 1'b1;
        #1;
        chk("rel_sready", {47'b0, s_ready}, 48'h1);
        chk("rel_ce", {47'b0, dsp_ce}, 48'h1);
        chk("rel_dsprst", {47'b0, dsp_rst}, 48'h0);
        @(negedge clk);

        for (int j = 0; j < NV; j++) run_vec(tbl[j], j);

        // Reset after 5 terms abandons the vector.
        s_sub = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_a     = 18'(k + 1);
            s_b     = 18'd2;
            @(posedge clk); @(negedge clk);
        end
        chk("mid_busy", {47'b0, busy}, 48'h1);
        s_valid = 1'b0;
        rstn    = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_sready", {47'b0, s_ready}, 48'h0);
        rstn = 1'b1;
        #1;
        chk("mid_rel_sready", {47'b0, s_ready}, 48'h1);
        chk("mid_rel_rvalid", {47'b0, r_valid}, 48'h0);
        chk("mid_rel_busy", {47'b0, busy}, 48'h0);
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (r_valid) quiet++;
        end
        chk("mid_no_partial", 48'(quiet), 48'd0);
        run_vec(tbl[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
